// File: rtl/vpipe_pkg.sv
// Shared instruction types for the simple pipeline and its feeders.
package vpipe_pkg;

  typedef enum logic [1:0] {
    OpNop = 2'd0,
    OpAdd = 2'd1,
    OpSub = 2'd2,
    OpXor = 2'd3
  } op_t;

  typedef struct packed {
    op_t        op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
  } inst_t;

  localparam inst_t NOP_INST = inst_t'(8'h00);

endpackage

// File: rtl/ifq_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module ifq_sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction FIFO feeding the pipeline; presents a NOP bubble when empty.
// Define IFQ_BYPASS_EN to forward in_inst_i straight to inst_o when the queue is empty.
module inst_fetch_queue
  import vpipe_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned LvlW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [7:0]       in_inst_i,
  output logic             in_ready_o,
  input  logic             issue_en_i,
  input  logic             flush_i,
  output logic [7:0]       inst_o,
  output logic             inst_valid_o,
  output logic [LvlW-1:0]  level_o,
  output logic [CNT_W-1:0] issue_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);

  inst_t           mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;

  logic head_valid, bypass;
  logic push_wr, pop_rd, issue_inc, bubble_inc;

  assign head_valid = (level_q != '0);
  assign in_ready_o = (level_q != LvlFull);
  assign level_o    = level_q;

`ifdef IFQ_BYPASS_EN
  assign bypass       = !head_valid && in_valid_i && !flush_i;
  assign inst_valid_o = head_valid || bypass;
  assign inst_o       = head_valid ? mem_q[rd_ptr_q] : (bypass ? in_inst_i : NOP_INST);
`else
  assign bypass       = 1'b0;
  assign inst_valid_o = head_valid;
  assign inst_o       = head_valid ? mem_q[rd_ptr_q] : NOP_INST;
`endif

  // A bypassed entry consumed this cycle never touches storage.
  assign push_wr    = in_valid_i && in_ready_o && !(bypass && issue_en_i) && !flush_i;
  assign pop_rd     = issue_en_i && head_valid && !flush_i;
  assign issue_inc  = issue_en_i && inst_valid_o && !flush_i;
  assign bubble_inc = issue_en_i && !inst_valid_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_rd)  rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + LvlW'(push_wr) - LvlW'(pop_rd);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted in level_q.
  always_ff @(posedge clk_i) begin
    if (push_wr) begin
      mem_q[wr_ptr_q] <= inst_t'(in_inst_i);
    end
  end

  ifq_sat_counter #(
    .Width(CNT_W)
  ) u_issue_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .inc_i (issue_inc),
    .cnt_o (issue_cnt_o)
  );

  ifq_sat_counter #(
    .Width(CNT_W)
  ) u_bubble_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .inc_i (bubble_inc),
    .cnt_o (bubble_cnt_o)
  );

endmodule
